// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: sequences the shared memory port of the multicycle CPU.
// Three requesters (fetch, data, exception vector) compete for the port.
// Each access holds the address selector for WAIT_CYCLES cycles and is
// followed by a one-cycle acknowledge to the winner.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN resolves fetch/data ties
// round-robin instead of the fixed data-over-fetch priority.
//
// state  | meaning
// IDLE   | port free, requests sampled and the winner granted
// ACCESS | address/strobe held, wait counter running down
// RESP   | one-cycle ack to the latched winner

module mem_access_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_fetch,
    input  logic       req_data,
    input  logic       data_we,
    input  logic       req_exc,
    input  logic [1:0] exc_code,
    output logic [2:0] iord_sel,
    output logic       mem_wr,
    output logic       ack_fetch,
    output logic       ack_data,
    output logic       ack_exc,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {W_FETCH, W_DATA, W_EXC} win_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state_q, state_d;
    win_t       win_q, win_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] sel_q, sel_d;
    logic       wr_q, wr_d;
    logic       pick_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // ptr_q = 0 means fetch wins the next fetch/data tie
    logic ptr_q, ptr_d;

    // round-robin pointer, flipped by every fetch or data grant
    always_ff @(posedge clk) begin
        if (!reset) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

    // tie between fetch and data follows the pointer
    always_comb begin
        ptr_d     = ptr_q;
        pick_data = req_data && (!req_fetch || ptr_q);
        if (state_q == IDLE && !req_exc && (req_data || req_fetch))
            ptr_d = ~ptr_q;
    end
`else
    // data always beats fetch
    always_comb begin
        pick_data = req_data;
    end
`endif

    // state and datapath registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            win_q   <= W_FETCH;
            cnt_q   <= 4'd0;
            sel_q   <= 3'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
        end
    end

    // next-state, grant and wait-counter logic
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        wr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_exc || req_data || req_fetch) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_LOAD;
                    if (req_exc) begin
                        win_d = W_EXC;
                        case (exc_code)
                            2'd0:    sel_d = 3'd2;
                            2'd1:    sel_d = 3'd3;
                            default: sel_d = 3'd4;
                        endcase
                    end else if (pick_data) begin
                        win_d = W_DATA;
                        sel_d = 3'd1;
                        wr_d  = data_we;
                    end else begin
                        win_d = W_FETCH;
                        sel_d = 3'd0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign iord_sel  = sel_q;
    assign mem_wr    = wr_q;
    assign busy      = (state_q != IDLE);
    assign ack_fetch = (state_q == RESP) && (win_q == W_FETCH);
    assign ack_data  = (state_q == RESP) && (win_q == W_DATA);
    assign ack_exc   = (state_q == RESP) && (win_q == W_EXC);

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences the single shared memory port of the multicycle CPU.
- Arbitrates between three requesters: instruction fetch, data load/store, and exception-vector reads.
- Drives the 3-bit IorD address-source selector and the memory write strobe.
- Inserts a fixed number of wait cycles per access and returns a one-cycle acknowledge to the winning requester.

Parameters:
- WAIT_CYCLES, 2, number of cycles the address and strobe are held per access; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req_fetch  input  1  instruction-fetch request (address source PC, selector 0).
- req_data  input  1  data-access request (address source ALUOut, selector 1).
- data_we  input  1  qualifies req_data: 1 = store, 0 = load; sampled with the grant.
- req_exc  input  1  exception-vector read request.
- exc_code  input  2  vector select: 0 → selector 2, 1 → selector 3, 2 or 3 → selector 4.
- iord_sel  output  3  IorD selector; only values 0..4 are ever driven.
- mem_wr  output  1  memory write enable.
- ack_fetch  output  1  one-cycle completion pulse for fetch.
- ack_data  output  1  one-cycle completion pulse for data.
- ack_exc  output  1  one-cycle completion pulse for exception read.
- busy  output  1  high in ACCESS and RESP.

Behaviour:
- Reset, sampled on a rising edge while reset = 0:
  - state = IDLE, iord_sel = 0, mem_wr = 0, all ack = 0, busy = 0, wait counter = 0, round-robin pointer = fetch.
  - Reset asserted mid-access aborts the access immediately; no ack is issued and mem_wr drops at that edge.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - If any request is high, register the winner, load iord_sel, load counter = WAIT_CYCLES-1, and go to ACCESS.
  - mem_wr goes to 1 on that edge only if the winner is data with data_we = 1.
  - With no request, stay in IDLE; iord_sel holds its last value.
- Fixed priority: exc > data > fetch. Simultaneous requests are resolved at the IDLE sampling edge only.
- ACCESS:
  - iord_sel and the latched winner are stable for exactly WAIT_CYCLES cycles.
  - mem_wr is high for the first ACCESS cycle only; it is never high for a load or exception read.
  - The counter decrements each cycle; at counter = 0 go to RESP.
  - Request inputs are ignored. A dropped request still completes and is still acked.
  - exc_code is sampled only at grant.
- RESP:
  - The matching ack_* is high for exactly one cycle; the others are 0.
  - Always returns to IDLE; there is no RESP→ACCESS shortcut.
- Latency: request sampled at edge N gives ACCESS at cycles N+1..N+WAIT_CYCLES and ack at cycle N+WAIT_CYCLES+1. Minimum spacing between grants is WAIT_CYCLES+2 cycles.
- Requester contract: req is held high until ack is seen and must be low in the cycle after ack (the IDLE cycle). A req still high there is treated as a new request.
- At most one ack is high in any cycle. mem_wr and ack are never high in the same cycle.
- Counter width is 4 bits; WAIT_CYCLES = 1 gives a single ACCESS cycle with no wrap.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- When defined:
  - The fetch/data tie is resolved round-robin. The pointer flips to the other requester each time fetch or data is granted.
  - exc keeps absolute priority and does not move the pointer.
  - Pointer resets to fetch, so the first fetch/data tie after reset goes to fetch.
- When undefined: fixed priority exc > data > fetch and no pointer register.

Test Plan:
- Reset, then req_fetch = 1 only, WAIT_CYCLES = 2 → iord_sel = 0 for 2 cycles, mem_wr = 0 throughout, ack_fetch high exactly 3 cycles after the sampling edge, busy high 3 cycles.
- req_data = 1, data_we = 1 → iord_sel = 1, mem_wr high in first ACCESS cycle only, ack_data 3 cycles after grant; repeat with data_we = 0 → mem_wr stays 0.
- req_fetch, req_data and req_exc all high, exc_code = 1 → iord_sel = 3 and ack_exc first; then data (iord_sel = 1), then fetch (iord_sel = 0). Grants are spaced 4 cycles apart and each ack is single.
- exc_code = 3 → iord_sel = 4. Drop req_exc during ACCESS → ack_exc still pulses. Change exc_code mid-access → iord_sel unchanged.
- reset = 0 during the first ACCESS cycle of a store → next cycle state IDLE, mem_wr = 0, no ack; after release a held req_data regrants.
- MEM_ARB_ROUND_ROBIN_EN defined, req_fetch and req_data held continuously → grants alternate fetch, data, fetch, data. Undefined → data wins the first tie.
